// File: rtl/id_stage.sv
// RV32I decode stage for OP / OP-IMM: reads a 32x32 register file (with write-back
// bypass) and presents ALU operands through a single registered valid/ready slot.
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_funct3,
    output logic            out_funct7,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // Handshake: a transfer happens on an edge where valid & ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.
    // Input side transfers on in_valid & in_ready, output side on out_valid & out_ready.

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [4:0]      rs1_idx, rs2_idx, rd_idx;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_val, shamt_val, op2_val;
    logic            legal, f7_bit, accept, wb_hit;

    assign opcode  = instr[6:0];
    assign rd_idx  = instr[11:7];
    assign f3      = instr[14:12];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign f7      = instr[31:25];

    assign imm_val   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign shamt_val = {{(XLEN-5){1'b0}}, instr[24:20]};

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign wb_hit   = wb_en && (wb_addr != 5'd0);

    // x0 reads as zero; a same-cycle write-back to the read index is forwarded.
    always_comb begin
        rs1_val = regs[rs1_idx];
        rs2_val = regs[rs2_idx];
        if (wb_hit && (wb_addr == rs1_idx)) rs1_val = wb_data;
        if (wb_hit && (wb_addr == rs2_idx)) rs2_val = wb_data;
        if (rs1_idx == 5'd0) rs1_val = '0;
        if (rs2_idx == 5'd0) rs2_val = '0;
    end

    always_comb begin
        legal   = 1'b0;
        op2_val = rs2_val;
        f7_bit  = 1'b0;
        case (opcode)
            OPC_OP: begin
                op2_val = rs2_val;
                f7_bit  = instr[30];
                legal   = (f7 == F7_ZERO) ||
                          ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                case (f3)
                    3'b001: begin
                        op2_val = shamt_val;
                        legal   = (f7 == F7_ZERO);
                    end
                    3'b101: begin
                        op2_val = shamt_val;
                        f7_bit  = instr[30];
                        legal   = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    end
                    default: begin
                        // immediate forms never carry the SUB modifier
                        op2_val = imm_val;
                        legal   = 1'b1;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            out_valid  <= 1'b0;
            illegal    <= 1'b0;
            out_funct3 <= '0;
            out_funct7 <= 1'b0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_we     <= 1'b0;
        end else begin
            if (wb_hit) regs[wb_addr] <= wb_data;
            illegal <= accept && !legal;
            if (accept && legal) begin
                out_valid  <= 1'b1;
                out_funct3 <= f3;
                out_funct7 <= f7_bit;
                out_rs1    <= rs1_val;
                out_rs2    <= op2_val;
                out_rd     <= rd_idx;
                out_we     <= (rd_idx != 5'd0);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: drivers push expected slots into a queue, a negedge
// monitor compares every presented slot (including held slots) against the queue head.
module tb_id_stage;

    localparam int W = 74;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_funct3;
    logic        out_funct7;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        illegal;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int stalls = 0;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_we(out_we), .illegal(illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pk(input logic [2:0] f3, input logic f7,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] rd, input logic we);
        return {f3, f7, a, b, rd, we};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL slot: unexpected out_valid with empty queue, got %0h",
                         {out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_we});
            end else begin
                chk("slot", {out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_we}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    // Offers ins until accepted; returns at accept edge + 1 with in_valid still high.
    task automatic send(input string name, input logic [31:0] ins, input logic is_legal,
                        input logic [W-1:0] exp);
        bit done = 0;
        in_valid = 1'b1;
        instr = ins;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (is_legal) exp_q.push_back(exp);
            end else begin
                stalls++;
            end
            step();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: not accepted within 20 cycles, got in_ready=%0b required 1", name, in_ready);
        end else begin
            chk({name, "_illegal"}, W'(illegal), W'(!is_legal));
            if (!is_legal) chk({name, "_in_ready"}, W'(in_ready), W'(1'b1));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    logic [11:0] imms [8] = '{12'h001, 12'h7FF, 12'h800, 12'hFFF, 12'h123, 12'h000, 12'hABC, 12'h555};

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_illegal", W'(illegal), '0);
        chk("rst_fields", {out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_we}, '0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", W'(in_ready), W'(1'b1));

        wb(5'd5, 32'h10);
        wb(5'd6, 32'h3);
        wb(5'd1, 32'hFFFF_FFFF);

        send("sub", 32'h406283B3, 1, pk(3'b000, 1, 32'h10, 32'h3, 5'd7, 1));
        send("addi", 32'hFFF00093, 1, pk(3'b000, 0, 32'h0, 32'hFFFF_FFFF, 5'd1, 1));
        send("srai", 32'h4040D113, 1, pk(3'b101, 1, 32'hFFFF_FFFF, 32'h4, 5'd2, 1));
        send("slli", 32'h00309113, 1, pk(3'b001, 0, 32'hFFFF_FFFF, 32'h3, 5'd2, 1));
        idle(2);

        // stall: slot held three cycles while the next instruction waits
        out_ready = 1'b0;
        send("add_stall", 32'h006281B3, 1, pk(3'b000, 0, 32'h10, 32'h3, 5'd3, 1));
        fork
            send("xor_after", 32'h0062C433, 1, pk(3'b100, 0, 32'h10, 32'h3, 5'd8, 1));
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", W'(in_ready), '0);
                end
                step();
                out_ready = 1'b1;
            end
        join
        idle(2);

        // bypass on rs1; x0 is never written nor forwarded
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEAD_BEEF;
        send("bypass", 32'h000201B3, 1, pk(3'b000, 0, 32'hDEAD_BEEF, 32'h0, 5'd3, 1));
        wb_en = 1'b0;
        idle(1);
        wb(5'd0, 32'h55);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
        send("x0_read", 32'h000001B3, 1, pk(3'b000, 0, 32'h0, 32'h0, 5'd3, 1));
        wb_en = 1'b0;
        idle(1);

        // illegal encodings are consumed without loading the slot
        send("lw", 32'h00002003, 0, '0);
        send("slli_alt", 32'h40309113, 0, '0);
        idle(1);
        chk("illegal_clear", W'(illegal), '0);
        chk("illegal_no_slot", W'(out_valid), '0);

        // back-to-back: one instruction per cycle
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            logic [4:0] rd;
            rd = 5'(i);
            send("b2b", {imms[i], 5'd0, 3'b000, rd, 7'b0010011}, 1,
                 pk(3'b000, 0, 32'h0, {{20{imms[i][11]}}, imms[i]}, rd, (i != 0)));
        end
        chk("b2b_no_stall", W'(stalls), '0);
        idle(2);

        // reset while a slot is held, with a write-back in the same cycle
        out_ready = 1'b0;
        send("held", 32'h006281B3, 1, pk(3'b000, 0, 32'h10, 32'h3, 5'd3, 1));
        in_valid = 1'b0;
        rst_n = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h99;
        step();
        wb_en = 1'b0;
        exp_q.delete();
        chk("midrst_out_valid", W'(out_valid), '0);
        chk("midrst_fields", {out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_we}, '0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        send("post_rst_x5", 32'h006281B3, 1, pk(3'b000, 0, 32'h0, 32'h0, 5'd3, 1));
        send("post_rst_x10", 32'h005501B3, 1, pk(3'b000, 0, 32'h0, 32'h0, 5'd3, 1));
        idle(3);

        chk("queue_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly upstream of the single-cycle-registered ALU.
- Accepts one 32-bit RV32I instruction per handshake and reads operands from an internal 32x32 register file, with a write-back port from the downstream stage.
- Presents funct3/funct7/operand fields to the ALU through a registered valid/ready output slot.
- Supports OP (0110011) and OP-IMM (0010011) only; all other encodings are flagged illegal and dropped.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, register count; x0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the stage can accept an instruction this cycle.
- instr  in  32  instruction word.
- wb_en  in  1  register write enable from write-back.
- wb_addr  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- out_valid  out  1  the output slot holds a decoded instruction.
- out_ready  in  1  the ALU stage consumes the slot.
- out_funct3  out  3  ALU operation select.
- out_funct7  out  1  ADD/SUB and SRL/SRA modifier.
- out_rs1  out  32  operand A.
- out_rs2  out  32  operand B: register value or immediate.
- out_rd  out  5  destination register.
- out_we  out  1  result is to be written back; 0 when rd = x0.
- illegal  out  1  one-cycle pulse: an accepted instruction was illegal.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - out_valid=0, illegal=0, out_funct3=0, out_funct7=0, out_rs1=0, out_rs2=0, out_rd=0, out_we=0.
  - All registers x0..x31 are cleared to 0.
  - Reset asserted mid-stall discards the held slot; no write-back is performed that cycle.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept occurs when in_valid & in_ready.
  - Output changes only on accept or drain. While out_valid & !out_ready, every out_* signal holds stable.
  - On an edge with accept of a legal instruction: the slot loads and out_valid=1. Latency is 1 cycle from accept to out_valid.
  - On an edge with out_ready and no legal accept: out_valid=0.
- Register file:
  - Writes on the edge when wb_en=1 and wb_addr≠0. Writes to x0 are ignored.
  - Reads occur in the accept cycle. Write-through bypass: if wb_en & wb_addr≠0 & wb_addr equals the read index in the same cycle, the operand takes wb_data.
  - A read of x0 always returns 0.
  - Operands are captured at accept. A write-back arriving while the slot is stalled does not update the held operands; hazard avoidance beyond same-cycle bypass belongs to the issuer.
- Decode, with fields rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], f3=instr[14:12], f7=instr[31:25]:
  - OP: out_rs2 = reg[rs2]. Legal when f7=0000000 (any f3), or f7=0100000 with f3 ∈ {000, 101}. out_funct7 = instr[30].
  - OP-IMM, f3 ∉ {001, 101}: out_rs2 = sign-extended instr[31:20]; out_funct7 = 0, so ADDI never becomes SUB. Always legal.
  - OP-IMM, f3 = 001: legal only when f7 = 0000000. out_rs2 = {27'b0, instr[24:20]}; out_funct7 = 0.
  - OP-IMM, f3 = 101: legal when f7 ∈ {0000000, 0100000}. out_rs2 = zero-extended shamt; out_funct7 = instr[30].
  - In all legal cases: out_rs1 = reg[rs1], out_funct3 = f3, out_rd = rd, out_we = (rd ≠ 0).
- Illegal instructions (any other opcode or forbidden f7):
  - The instruction is still consumed (in_ready unaffected).
  - illegal pulses 1 for exactly the cycle after accept, and the slot is not loaded.
  - If the slot drains in the same edge, out_valid goes 0. A held valid slot stays held.
- Simultaneous accept and drain: the new instruction replaces the slot and out_valid stays 1, giving full throughput of 1 instruction per cycle.
- Widths: the immediate is sign-extended to XLEN. Shift amounts never exceed 5 bits on out_rs2.

Test Plan:
- Reset then write-back x5=0x0000_0010, x6=0x0000_0003; issue SUB x7,x5,x6 (0x406283B3) → next cycle out_valid=1, funct3=000, funct7=1, rs1=0x10, rs2=0x3, rd=7, we=1.
- ADDI x1,x0,-1 (0xFFF00093) → rs1=0, rs2=0xFFFF_FFFF, funct7=0. SRAI x2,x1,4 (0x4040D113) → rs2=0x4, funct7=1, funct3=101.
- Stall: out_ready=0 for 3 cycles after accept, with new instr offered → in_ready=0, outputs unchanged; on out_ready=1, the next instr loads on the following edge.
- Bypass: same cycle as accept of ADD x3,x4,x0, wb_en=1, wb_addr=4, wb_data=0xDEAD_BEEF → out_rs1=0xDEAD_BEEF. Write-back to x0 with 0x55, then read x0 → 0.
- Illegal: LW opcode 0x0000_2003, and SLLI with f7=0100000 → illegal=1 for one cycle, out_valid stays 0, in_ready stays 1.
- Back-to-back: 8 legal instrs with in_valid=1 and out_ready=1 → 8 consecutive out_valid cycles in order. Assert rst_n=0 mid-stream → out_valid=0 and registers read 0 next access.
